// File: rtl/octree_pkg.sv
// Shared octree definitions: level-base helper, decoder FSM states and the node path typedefs
// used by both the forward address calculator and the decoder.
package octree_pkg;

    localparam int unsigned TreeLevel   = 5;
    localparam int unsigned LogChildNum = 3;
    localparam int unsigned LevelWidth  = $clog2(TreeLevel + 1);
    localparam int unsigned BaseWidth   = 129;

    typedef logic [LevelWidth-1:0]  level_t;
    typedef logic [LogChildNum-1:0] child_t;
    typedef child_t [TreeLevel-1:0] offset_t;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StExtract,
        StDone
    } state_e;

    // First node address of a level relative to the root: sum of the sizes of all shallower levels.
    function automatic logic [BaseWidth-1:0] level_base(input int unsigned level,
                                                        input int unsigned log_child_num);
        logic [BaseWidth-1:0] sum;
        sum = '0;
        for (int unsigned k = 0; k < level; k++) begin
            sum = sum + (BaseWidth'(1) << (log_child_num * k));
        end
        return sum;
    endfunction

endpackage

// File: rtl/octree_addr_decode_if.sv
// Request/result bundle of the octree address decoder; master drives requests, slave decodes.
interface octree_addr_decode_if #(
    parameter int unsigned TREE_LEVEL    = 5,
    parameter int unsigned LOG_CHILD_NUM = 3,
    parameter int unsigned ADDR_WIDTH    = 64
);

    logic                                     in_valid;
    logic                                     in_ready;
    logic [ADDR_WIDTH-1:0]                    in_addr;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [$clog2(TREE_LEVEL + 1)-1:0]        out_level;
    logic [TREE_LEVEL-1:0][LOG_CHILD_NUM-1:0] out_offset;
    logic                                     out_error;

    modport master (
        output in_valid,
        output in_addr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_level,
        input  out_offset,
        input  out_error
    );

    modport slave (
        input  in_valid,
        input  in_addr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_level,
        output out_offset,
        output out_error
    );

endinterface

// File: rtl/octree_addr_decode.sv
// Maps a linear octree node address back to its level and root-to-node child path, one level
// compare per cycle while searching and one child digit per cycle while extracting.
module octree_addr_decode
    import octree_pkg::*;
#(
    parameter int unsigned           TREE_LEVEL      = TreeLevel,
    parameter int unsigned           LOG_CHILD_NUM   = LogChildNum,
    parameter int unsigned           ADDR_WIDTH      = 64,
    parameter logic [ADDR_WIDTH-1:0] TREE_ADDR_START = '0
) (
    input logic                clk,
    input logic                rst_n,
    octree_addr_decode_if.slave bus
);

    localparam int unsigned LevelW = $clog2(TREE_LEVEL + 1);
    localparam int unsigned IdxW   = $clog2(TREE_LEVEL + 2);
    localparam int unsigned BaseW  = ADDR_WIDTH + 1;

    state_e                                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]                    rel_q, rel_d;
    logic [ADDR_WIDTH-1:0]                    idx_q, idx_d;
    logic                                     underflow_q, underflow_d;
    logic [IdxW-1:0]                          search_q, search_d, search_nxt;
    logic [LevelW-1:0]                        level_q, level_d;
    logic [LevelW-1:0]                        k_q, k_d;
    logic [LevelW-1:0]                        wr_pos;
    logic [TREE_LEVEL-1:0][LOG_CHILD_NUM-1:0] offset_q, offset_d;
    logic                                     error_q, error_d;
    logic [BaseW-1:0]                         cur_base, nxt_base;
    logic                                     hit;

    // Level bases are one bit wider than the address so the base past the deepest level fits.
    logic [BaseW-1:0] base_tbl [TREE_LEVEL+2];
    for (genvar g = 0; g < TREE_LEVEL + 2; g++) begin : g_base
        assign base_tbl[g] = BaseW'(level_base(g, LOG_CHILD_NUM));
    end

    assign search_nxt = search_q + IdxW'(1);

    always_comb begin
        cur_base = '0;
        nxt_base = '0;
        for (int unsigned i = 0; i < TREE_LEVEL + 2; i++) begin
            if (search_q == IdxW'(i)) begin
                cur_base = base_tbl[i];
            end
            if (search_nxt == IdxW'(i)) begin
                nxt_base = base_tbl[i];
            end
        end
    end

    assign hit = {1'b0, rel_q} < nxt_base;

    always_comb begin
        state_d     = state_q;
        rel_d       = rel_q;
        idx_d       = idx_q;
        underflow_d = underflow_q;
        search_d    = search_q;
        level_d     = level_q;
        k_d         = k_q;
        offset_d    = offset_q;
        error_d     = error_q;
        wr_pos      = level_q - k_q - LevelW'(1);

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    rel_d       = bus.in_addr - TREE_ADDR_START;
                    underflow_d = bus.in_addr < TREE_ADDR_START;
                    offset_d    = '0;
                    level_d     = '0;
                    error_d     = 1'b0;
                    search_d    = '0;
                    state_d     = StSearch;
                end
            end
            StSearch: begin
                if (underflow_q) begin
                    error_d = 1'b1;
                    state_d = StDone;
                end else if (hit) begin
                    level_d = LevelW'(search_q);
                    idx_d   = ADDR_WIDTH'({1'b0, rel_q} - cur_base);
                    k_d     = '0;
                    state_d = (search_q == '0) ? StDone : StExtract;
                end else if (search_q == IdxW'(TREE_LEVEL)) begin
                    error_d = 1'b1;
                    state_d = StDone;
                end else begin
                    search_d = search_nxt;
                end
            end
            StExtract: begin
                // Lowest digit of the in-level index is the child taken at the deepest depth.
                for (int unsigned i = 0; i < TREE_LEVEL; i++) begin
                    if (wr_pos == LevelW'(i)) begin
                        offset_d[i] = idx_q[LOG_CHILD_NUM-1:0];
                    end
                end
                idx_d = idx_q >> LOG_CHILD_NUM;
                k_d   = k_q + LevelW'(1);
                if (k_q == level_q - LevelW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rel_q       <= '0;
            idx_q       <= '0;
            underflow_q <= 1'b0;
            search_q    <= '0;
            level_q     <= '0;
            k_q         <= '0;
            offset_q    <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rel_q       <= rel_d;
            idx_q       <= idx_d;
            underflow_q <= underflow_d;
            search_q    <= search_d;
            level_q     <= level_d;
            k_q         <= k_d;
            offset_q    <= offset_d;
            error_q     <= error_d;
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.out_valid  = (state_q == StDone);
    assign bus.out_level  = level_q;
    assign bus.out_offset = offset_q;
    assign bus.out_error  = error_q;

endmodule

// File: tb/tb_octree_addr_decode.sv
// Directed and round-trip checks of the octree address decoder with a 4-level octree.
module tb_octree_addr_decode;

    localparam int unsigned TL  = 4;
    localparam int unsigned LCN = 3;
    localparam int unsigned AW  = 64;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    // Level bases for a 4-level octree, computed by hand.
    logic [63:0] base [6];

    octree_addr_decode_if #(.TREE_LEVEL(TL), .LOG_CHILD_NUM(LCN), .ADDR_WIDTH(AW)) bus0 ();
    octree_addr_decode_if #(.TREE_LEVEL(TL), .LOG_CHILD_NUM(LCN), .ADDR_WIDTH(AW)) bus1 ();

    octree_addr_decode #(
        .TREE_LEVEL     (TL),
        .LOG_CHILD_NUM  (LCN),
        .ADDR_WIDTH     (AW),
        .TREE_ADDR_START(64'd0)
    ) u_dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    octree_addr_decode #(
        .TREE_LEVEL     (TL),
        .LOG_CHILD_NUM  (LCN),
        .ADDR_WIDTH     (AW),
        .TREE_ADDR_START(64'd100)
    ) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] mk_off(input int d0, input int d1, input int d2, input int d3);
        logic [3:0][2:0] o;
        o[0] = 3'(d0);
        o[1] = 3'(d1);
        o[2] = 3'(d2);
        o[3] = 3'(d3);
        return o;
    endfunction

    // Issue one request on dut0 (out_ready high) and check the result and its latency.
    task automatic run_decode(input string tag, input logic [63:0] addr, input int exp_level,
                              input logic [11:0] exp_off, input logic exp_err, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, "/in_ready"}, 64'(bus0.in_ready), 64'd1);
        bus0.in_valid = 1'b1;
        bus0.in_addr  = addr;
        @(posedge clk);
        #1 bus0.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus0.out_valid && lat < 40);
        check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "/level"}, 64'(bus0.out_level), 64'(exp_level));
        check({tag, "/offset"}, 64'(bus0.out_offset), 64'(exp_off));
        check({tag, "/error"}, 64'(bus0.out_error), 64'(exp_err));
        @(posedge clk);
        @(negedge clk);
        check({tag, "/valid_drop"}, 64'(bus0.out_valid), 64'd0);
    endtask

    initial begin
        int              lat;
        int              vcount;
        int              lvl;
        logic [63:0]     idx;
        logic [3:0][2:0] off;

        n_tests = 0;
        n_fail  = 0;
        base[0] = 64'd0;
        base[1] = 64'd1;
        base[2] = 64'd9;
        base[3] = 64'd73;
        base[4] = 64'd585;
        base[5] = 64'd4681;

        rst_n          = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.in_addr   = '0;
        bus0.out_ready = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_addr   = '0;
        bus1.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/in_ready", 64'(bus0.in_ready), 64'd1);
        check("reset/out_valid", 64'(bus0.out_valid), 64'd0);
        check("reset/level", 64'(bus0.out_level), 64'd0);
        check("reset/offset", 64'(bus0.out_offset), 64'd0);
        check("reset/error", 64'(bus0.out_error), 64'd0);
        rst_n = 1'b1;

        run_decode("root", 64'd0, 0, mk_off(0, 0, 0, 0), 1'b0, 2);
        run_decode("a1", 64'd1, 1, mk_off(0, 0, 0, 0), 1'b0, 4);
        run_decode("a8", 64'd8, 1, mk_off(7, 0, 0, 0), 1'b0, 4);
        run_decode("a19", 64'd19, 2, mk_off(1, 2, 0, 0), 1'b0, 6);
        run_decode("a584", 64'd584, 3, mk_off(7, 7, 7, 0), 1'b0, 8);
        run_decode("a1308", 64'd1308, 4, mk_off(1, 3, 2, 3), 1'b0, 10);
        run_decode("a4680", 64'd4680, 4, mk_off(7, 7, 7, 7), 1'b0, 10);
        run_decode("over", 64'd4681, 0, mk_off(0, 0, 0, 0), 1'b1, 6);
        run_decode("over_max", 64'hFFFF_FFFF_FFFF_FFFF, 0, mk_off(0, 0, 0, 0), 1'b1, 6);

        // Address below the tree start on the offset instance.
        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.in_addr  = 64'd50;
        @(posedge clk);
        #1 bus1.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus1.out_valid && lat < 40);
        check("under/latency", 64'(lat), 64'd2);
        check("under/error", 64'(bus1.out_error), 64'd1);
        check("under/level", 64'(bus1.out_level), 64'd0);
        check("under/offset", 64'(bus1.out_offset), 64'd0);
        run_decode("after_under", 64'd19, 2, mk_off(1, 2, 0, 0), 1'b0, 6);

        // Back-pressure: result held, new request ignored while in DONE.
        bus0.out_ready = 1'b0;
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.in_addr  = 64'd19;
        @(posedge clk);
        #1 bus0.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus0.out_valid && lat < 40);
        check("stall/latency", 64'(lat), 64'd6);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                bus0.in_valid = 1'b1;
                bus0.in_addr  = 64'd0;
            end
            check("stall/valid", 64'(bus0.out_valid), 64'd1);
            check("stall/in_ready", 64'(bus0.in_ready), 64'd0);
            check("stall/level", 64'(bus0.out_level), 64'd2);
            check("stall/offset", 64'(bus0.out_offset), 64'(mk_off(1, 2, 0, 0)));
            @(posedge clk);
            #1 bus0.in_valid = 1'b0;
            @(negedge clk);
        end
        bus0.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall/release_valid", 64'(bus0.out_valid), 64'd0);
        check("stall/release_ready", 64'(bus0.in_ready), 64'd1);
        @(negedge clk);
        check("stall/no_accept", 64'(bus0.in_ready), 64'd1);

        // Reset in the middle of a level-4 search.
        bus0.in_valid = 1'b1;
        bus0.in_addr  = 64'd1308;
        @(posedge clk);
        #1 bus0.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst/in_ready", 64'(bus0.in_ready), 64'd1);
        check("rst/level", 64'(bus0.out_level), 64'd0);
        check("rst/offset", 64'(bus0.out_offset), 64'd0);
        check("rst/error", 64'(bus0.out_error), 64'd0);
        vcount = 0;
        for (int c = 0; c < 15; c++) begin
            if (bus0.out_valid) vcount++;
            @(negedge clk);
        end
        check("rst/no_valid", 64'(vcount), 64'd0);

        // Round trips through a forward model.
        for (int n = 0; n < 1000; n++) begin
            lvl = int'($urandom_range(0, 4));
            off = '0;
            idx = '0;
            for (int i = 0; i < lvl; i++) begin
                off[i] = 3'($urandom_range(0, 7));
                idx    = (idx << 3) | 64'(off[i]);
            end
            run_decode("rt", base[lvl] + idx, lvl, off, 1'b0, 2 + 2 * lvl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
